cross_window_streamer: RTL and testbench

//  Streaming front end for the image-sharpening convolution. Accepts one raster-order
//  8-bit pixel per cycle. Emits, per image pixel, the 5-point cross window (N,W,C,E,S)

---
 rtl/img_pkg.sv | 38 +++
 rtl/line_buffer.sv | 29 ++
 rtl/cross_window_streamer.sv | 165 ++++++++++++++++
 tb/tb_cross_window_streamer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// img_pkg: shared definitions for the image-sharpening front end and the
// Laplacian stage that consumes its windows.
//   - default frame geometry and pixel width
//   - streamer FSM state encoding
//   - cross window tap order and a default-width window struct
package img_pkg;

  localparam int IMG_W_DEF = 128;
  localparam int IMG_H_DEF = 128;
  localparam int PIX_W_DEF = 8;

  // FILL   : loading row 0, no windows yet
  // STREAM : each accepted pixel (r+1,c) releases window (r,c)
  // FLUSH  : input closed, last row drained with S padded to 0
  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  // Tap order of a packed window, most significant first.
  typedef enum logic [2:0] {
    TAP_N = 3'd0,
    TAP_W = 3'd1,
    TAP_C = 3'd2,
    TAP_E = 3'd3,
    TAP_S = 3'd4
  } tap_e;

  typedef struct packed {
    logic [PIX_W_DEF-1:0] n;
    logic [PIX_W_DEF-1:0] w;
    logic [PIX_W_DEF-1:0] c;
    logic [PIX_W_DEF-1:0] e;
    logic [PIX_W_DEF-1:0] s;
  } win8_t;

endpackage

// File: rtl/line_buffer.sv
// line_buffer: one image row of storage, one write port and one read port,
// read data registered (one cycle from raddr to rdata). Contents are not reset.
//   clk   : clock
//   we    : write enable
//   waddr : write column
//   wdata : write pixel
//   raddr : read column, sampled every cycle
//   rdata : mem[raddr] from the previous cycle (old data on same-address write)
module line_buffer #(
  parameter  int DEPTH = 128,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/cross_window_streamer.sv
// cross_window_streamer: raster pixel stream in, 5-point cross window
// (N,W,C,E,S) out, zero padded at the image border, built on two line buffers.
//   clk, rst          : clock, synchronous active-high reset
//   in_pixel/in_valid : raster-order input pixel
//   in_ready          : low only while the last row is being flushed
//   win_n..win_s      : registered window taps, hold when out_valid=0
//   out_valid         : one window this cycle, no backpressure
//   frame_done        : pulse with window (IMG_H-1,IMG_W-1)
//
// The two buffers swap roles at every row end: the "north" buffer holds row
// r-1 and is overwritten in place by the incoming row r+1; the "centre"
// buffer holds row r. The centre buffer is read one column ahead (E tap),
// the centre pixel itself rides in c_reg and the W tap in prev_c. Both
// buffers are addressed from next-cycle state so the registered read data is
// already valid on the cycle a pixel can be accepted.
module cross_window_streamer
  import img_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] win_n,
  output logic [PIX_W-1:0] win_w,
  output logic [PIX_W-1:0] win_c,
  output logic [PIX_W-1:0] win_e,
  output logic [PIX_W-1:0] win_s,
  output logic             out_valid,
  output logic             frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef struct packed {
    logic [PIX_W-1:0] n;
    logic [PIX_W-1:0] w;
    logic [PIX_W-1:0] c;
    logic [PIX_W-1:0] e;
    logic [PIX_W-1:0] s;
  } win_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col, col_nxt, col_la;
  logic [RW-1:0] row, row_nxt;
  logic          sel, sel_nxt;     // 0: buf0 is north, 1: buf1 is north
  logic          xfer, advance, row_end;

  logic [CW-1:0]    raddr0, raddr1;
  logic [PIX_W-1:0] rd0, rd1, rd_north, rd_centre;
  logic [PIX_W-1:0] c_reg, prev_c, first_pix;
  win_t             win_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FILL;
      col   <= '0;
      row   <= '0;
      sel   <= 1'b0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
      sel   <= sel_nxt;
    end
  end

  always_comb begin
    in_ready  = (state != S_FLUSH);
    xfer      = in_valid & in_ready;
    // FLUSH steps one column per cycle on its own; otherwise a transfer steps.
    advance   = (state == S_FLUSH) | xfer;
    row_end   = advance & (col == CW'(IMG_W - 1));
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    sel_nxt   = sel;
    if (advance) col_nxt = row_end ? '0 : col + CW'(1);
    if (row_end) sel_nxt = ~sel;
    case (state)
      S_FILL: if (row_end) begin
        state_nxt = S_STREAM;
        row_nxt   = RW'(1);
      end
      S_STREAM: if (row_end) begin
        if (row == RW'(IMG_H - 1)) state_nxt = S_FLUSH;
        else                       row_nxt   = row + RW'(1);
      end
      S_FLUSH: if (row_end) begin
        state_nxt = S_FILL;
        row_nxt   = '0;
      end
      default: state_nxt = S_FILL;
    endcase
  end

  // --------------------------------------------------------- line buffers
  always_comb begin
    col_la = (col_nxt == CW'(IMG_W - 1)) ? '0 : col_nxt + CW'(1);
    raddr0 = sel_nxt ? col_la  : col_nxt;
    raddr1 = sel_nxt ? col_nxt : col_la;
    rd_north  = sel ? rd1 : rd0;
    rd_centre = sel ? rd0 : rd1;
  end

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk   (clk),
    .we    (xfer & ~sel),
    .waddr (col),
    .wdata (in_pixel),
    .raddr (raddr0),
    .rdata (rd0)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk   (clk),
    .we    (xfer & sel),
    .waddr (col),
    .wdata (in_pixel),
    .raddr (raddr1),
    .rdata (rd1)
  );

  // ------------------------------------------------------ window assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      c_reg      <= '0;
      prev_c     <= '0;
      first_pix  <= '0;
      win_q      <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= advance & (state != S_FILL);
      frame_done <= (state == S_FLUSH) & row_end;
      // Column 0 of the row being written is the first centre pixel of the
      // next row; it cannot be read back from the buffer in time.
      if (xfer && col == '0) first_pix <= in_pixel;
      if (advance) begin
        prev_c <= c_reg;
        c_reg  <= row_end ? first_pix : rd_centre;
      end
      if (advance && state != S_FILL) begin
        win_q.n <= (state == S_STREAM && row == RW'(1)) ? '0 : rd_north;
        win_q.w <= (col == '0) ? '0 : prev_c;
        win_q.c <= c_reg;
        win_q.e <= (col == CW'(IMG_W - 1)) ? '0 : rd_centre;
        win_q.s <= (state == S_FLUSH) ? '0 : in_pixel;
      end
    end
  end

  assign win_n = win_q.n;
  assign win_w = win_q.w;
  assign win_c = win_q.c;
  assign win_e = win_q.e;
  assign win_s = win_q.s;

endmodule

// File: tb/tb_cross_window_streamer.sv
module tb_cross_window_streamer;

  typedef struct packed {
    logic [7:0] n;
    logic [7:0] w;
    logic [7:0] c;
    logic [7:0] e;
    logic [7:0] s;
  } win_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_pixel = '0;
  logic       in_valid = 1'b0;
  logic       in_ready, out_valid, frame_done;
  logic [7:0] win_n, win_w, win_c, win_e, win_s;

  logic [7:0] in_pixel2 = '0;
  logic       in_valid2 = 1'b0;
  logic       in_ready2, out_valid2, frame_done2;
  logic [7:0] win_n2, win_w2, win_c2, win_e2, win_s2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cross_window_streamer #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid),
    .in_ready(in_ready), .win_n(win_n), .win_w(win_w), .win_c(win_c),
    .win_e(win_e), .win_s(win_s), .out_valid(out_valid), .frame_done(frame_done)
  );

  cross_window_streamer dut2 (
    .clk(clk), .rst(rst), .in_pixel(in_pixel2), .in_valid(in_valid2),
    .in_ready(in_ready2), .win_n(win_n2), .win_w(win_w2), .win_c(win_c2),
    .win_e(win_e2), .win_s(win_s2), .out_valid(out_valid2), .frame_done(frame_done2)
  );

  // ------------------------------------------------------------ model
  logic [7:0] img [16];
  win_t       exp_q [$];

  function automatic logic [7:0] px(input int r, input int c);
    if (r < 0 || r > 3 || c < 0 || c > 3) return 8'd0;
    return img[r*4 + c];
  endfunction

  function automatic win_t ref_win(input int r, input int c);
    win_t w;
    w.n = px(r-1, c); w.w = px(r, c-1); w.c = px(r, c);
    w.e = px(r, c+1); w.s = px(r+1, c);
    return w;
  endfunction

  task automatic expect_frame();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) exp_q.push_back(ref_win(r, c));
  endtask

  // ---------------------------------------------------------- monitors
  win_t obs_q [$];
  bit   fd_q  [$];
  int   rdy_low = 0;
  int   viol = 0;
  bit   prev_ok = 1'b0;

  always @(negedge clk) begin
    if (out_valid) begin
      obs_q.push_back({win_n, win_w, win_c, win_e, win_s});
      fd_q.push_back(frame_done);
    end
    if (out_valid && !prev_ok) viol++;
    if (!rst && !in_ready) rdy_low++;
    prev_ok = !rst && ((in_valid && in_ready) || !in_ready);
  end

  int cnt2 = 0, bad2 = 0, fd2 = 0, first_bad2 = -1;
  always @(negedge clk) begin
    if (out_valid2) begin
      int r, c;
      win_t e;
      r = cnt2 / 128;
      c = cnt2 % 128;
      e.n = (r == 0)   ? 8'd0 : 8'd200;
      e.s = (r == 127) ? 8'd0 : 8'd200;
      e.w = (c == 0)   ? 8'd0 : 8'd200;
      e.e = (c == 127) ? 8'd0 : 8'd200;
      e.c = 8'd200;
      if ({win_n2, win_w2, win_c2, win_e2, win_s2} !== e || frame_done2 !== (cnt2 == 16383)) begin
        bad2++;
        if (first_bad2 < 0) first_bad2 = cnt2;
      end
      cnt2++;
    end
    if (frame_done2) fd2++;
  end

  // ----------------------------------------------------------- drivers
  task automatic push(input logic [7:0] pix, input bit gaps);
    bit rdy;
    if (gaps) begin
      for (int g = 0; g < 8 && $urandom_range(1, 0) == 1; g++) begin
        @(negedge clk); in_valid = 1'b0; in_pixel = 8'($urandom);
      end
    end
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      in_valid = 1'b1; in_pixel = pix; rdy = in_ready;
      @(posedge clk);
      if (rdy) return;
    end
    checks++; errors++;
    $display("FAIL push_timeout: in_ready stuck low, pixel %0d not accepted", pix);
  endtask

  task automatic send_frame(input bit gaps);
    for (int k = 0; k < 16; k++) push(img[k], gaps);
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic wait_windows(input int n);
    int t;
    for (t = 0; t < 500 && obs_q.size() < n; t++) @(negedge clk);
    repeat (10) @(negedge clk);
    checks++;
    if (obs_q.size() !== n) begin
      errors++;
      $display("FAIL window_count: got %0d windows, want %0d", obs_q.size(), n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    obs_q.delete(); fd_q.delete(); exp_q.delete();
    rdy_low = 0; viol = 0;
  endtask

  // ------------------------------------------------------------- tests
  task automatic test_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({out_valid, frame_done, in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL reset_ctrl: out_valid/frame_done/in_ready=%b want 001",
               {out_valid, frame_done, in_ready});
    end
    checks++;
    if ({win_n, win_w, win_c, win_e, win_s} !== 40'd0) begin
      errors++;
      $display("FAIL reset_win: taps=%h want 0", {win_n, win_w, win_c, win_e, win_s});
    end
    obs_q.delete(); fd_q.delete(); rdy_low = 0; viol = 0;
  endtask

  task automatic test_frame();
    for (int k = 0; k < 16; k++) img[k] = 8'(16*(k/4) + k%4);
    expect_frame();
    send_frame(1'b0);
    wait_windows(16);
    for (int i = 0; i < 16 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || fd_q[i] !== (i == 15)) begin
        errors++;
        $display("FAIL frame_win%0d: got %h fd=%b want %h fd=%b", i, obs_q[i], fd_q[i],
                 exp_q[i], i == 15);
      end
    end
    if (obs_q.size() == 16) begin
      checks++;
      if (obs_q[5] !== {8'd1, 8'd16, 8'd17, 8'd18, 8'd33}) begin
        errors++; $display("FAIL win_1_1: got %h want 0110111221", obs_q[5]);
      end
      checks++;
      if (obs_q[0] !== {8'd0, 8'd0, 8'd0, 8'd1, 8'd16}) begin
        errors++; $display("FAIL corner_0_0: got %h want 0000000110", obs_q[0]);
      end
      checks++;
      if (obs_q[15] !== {8'd35, 8'd50, 8'd51, 8'd0, 8'd0}) begin
        errors++; $display("FAIL corner_3_3: got %h want 2332330000", obs_q[15]);
      end
    end
    checks++;
    if (rdy_low !== 4) begin
      errors++; $display("FAIL flush_len: in_ready low %0d cycles want 4", rdy_low);
    end
    do_reset();
  endtask

  task automatic test_gaps();
    for (int k = 0; k < 16; k++) img[k] = 8'(16*(k/4) + k%4);
    expect_frame();
    send_frame(1'b1);
    wait_windows(16);
    for (int i = 0; i < 16 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || fd_q[i] !== (i == 15)) begin
        errors++;
        $display("FAIL gap_win%0d: got %h fd=%b want %h", i, obs_q[i], fd_q[i], exp_q[i]);
      end
    end
    checks++;
    if (rdy_low !== 4) begin
      errors++; $display("FAIL gap_flush_len: in_ready low %0d cycles want 4", rdy_low);
    end
    checks++;
    if (viol !== 0) begin
      errors++; $display("FAIL gap_spurious_valid: %0d unexplained out_valid cycles want 0", viol);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 16; k++) img[k] = 8'($urandom);
    expect_frame();
    send_frame(1'b0);
    for (int k = 0; k < 16; k++) img[k] = 8'd255 - img[k];
    expect_frame();
    send_frame(1'b0);
    wait_windows(32);
    for (int i = 0; i < 32 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || fd_q[i] !== (i == 15 || i == 31)) begin
        errors++;
        $display("FAIL b2b_win%0d: got %h fd=%b want %h", i, obs_q[i], fd_q[i], exp_q[i]);
      end
    end
    for (int c = 0; c < 4 && obs_q.size() == 32; c++) begin
      checks++;
      if (obs_q[16 + c].n !== 8'd0) begin
        errors++; $display("FAIL b2b_top_n%0d: got %0d want 0", c, obs_q[16 + c].n);
      end
    end
    checks++;
    if (rdy_low !== 8) begin
      errors++; $display("FAIL b2b_flush_len: in_ready low %0d cycles want 8", rdy_low);
    end
    do_reset();
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 7; k++) push(8'($urandom), 1'b0);
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({out_valid, frame_done, in_ready, win_n, win_w, win_c, win_e, win_s} !== {3'b001, 40'd0}) begin
      errors++;
      $display("FAIL midrst_outputs: got %h want %h",
               {out_valid, frame_done, in_ready, win_n, win_w, win_c, win_e, win_s}, {3'b001, 40'd0});
    end
    obs_q.delete(); fd_q.delete(); exp_q.delete(); rdy_low = 0; viol = 0;
    for (int k = 0; k < 16; k++) img[k] = 8'($urandom);
    expect_frame();
    send_frame(1'b1);
    wait_windows(16);
    for (int i = 0; i < 16 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL midrst_win%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    do_reset();
  endtask

  task automatic test_default_128();
    bit rdy;
    for (int k = 0; k < 128*128; k++) begin
      rdy = 1'b0;
      for (int t = 0; t < 50 && !rdy; t++) begin
        @(negedge clk); in_valid2 = 1'b1; in_pixel2 = 8'd200; rdy = in_ready2;
        @(posedge clk);
      end
      if (!rdy) begin
        checks++; errors++;
        $display("FAIL big_push_timeout: pixel %0d not accepted", k);
        break;
      end
    end
    @(negedge clk); in_valid2 = 1'b0;
    for (int t = 0; t < 1000 && cnt2 < 16384; t++) @(negedge clk);
    repeat (10) @(negedge clk);
    checks++;
    if (cnt2 !== 16384) begin
      errors++; $display("FAIL big_count: got %0d windows want 16384", cnt2);
    end
    checks++;
    if (bad2 !== 0) begin
      errors++; $display("FAIL big_windows: %0d wrong windows (first at %0d) want 0", bad2, first_bad2);
    end
    checks++;
    if (fd2 !== 1) begin
      errors++; $display("FAIL big_frame_done: %0d pulses want 1", fd2);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_gaps();
    test_back_to_back();
    test_mid_reset();
    test_default_128();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
